fpu_ds_ctrl: RTL

Sequencer for the shared iterative divide/square-root unit that sits beside the pipelined FP adder in the FPU. Accepts an fdiv/fsqrt from the ID stage, drives the iterative unit for a fixed number of cycles, generates the `st_ds` stall for dependent or conflicting FP instructions, and arbitrates the single FP writeback (W) slot against results leaving adder stage E3. The adder pipeline always has priority; the divide/sqrt result waits for a free W slot.

---
 rtl/fpu_ds_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/fpu_ds_ctrl.sv
// Sequencer for the shared iterative divide/sqrt unit.
// Drives the iteration, raises the ID stall and arbitrates the W slot.
module fpu_ds_ctrl #(
  parameter int unsigned DIV_CYCLES  = 14,
  parameter int unsigned SQRT_CYCLES = 14
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       e,
  input  logic       start_div,
  input  logic       start_sqrt,
  input  logic [4:0] fd,
  input  logic [4:0] fs,
  input  logic [4:0] ft,
  input  logic       use_fs,
  input  logic       use_ft,
  input  logic       wf,
  input  logic       e3w,
  output logic       st_ds,
  output logic       busy,
  output logic       ds_load,
  output logic       ds_step,
  output logic       ds_op,
  output logic       ds_ww,
  output logic [4:0] ds_wn,
  output logic       wb_sel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LD  = 8'(DIV_CYCLES - 1);
  localparam logic [7:0] SQRT_LD = 8'(SQRT_CYCLES - 1);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic       op_q;
  logic [4:0] wn_q;
  logic       start;
  logic       hazard;

  assign start = start_div | start_sqrt;

  // Combinational handshakes; reset forces the load request low.
  always_comb begin
    busy    = (state_q != IDLE);
    ds_load = clrn & (state_q == IDLE) & e & start;
    ds_step = (state_q == RUN);
    ds_ww   = (state_q == WB) & e & ~e3w;
    wb_sel  = ds_ww;
    hazard  = start
            | (use_fs & (fs == wn_q))
            | (use_ft & (ft == wn_q))
            | (wf & (fd == wn_q));
    st_ds   = busy & hazard;
    ds_op   = op_q;
    ds_wn   = wn_q;
  end

  // Sequencer state, iteration counter and latched op/destination.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      wn_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ds_load) begin
            op_q    <= start_sqrt;
            wn_q    <= fd;
            cnt_q   <= start_sqrt ? SQRT_LD : DIV_LD;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (cnt_q == 8'd0) state_q <= WB;
          else cnt_q <= cnt_q - 8'd1;
        end
        WB: begin
          if (ds_ww) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
